id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the RV64 pipeline; sits directly downstream of the decode control unit.
- Each cycle it captures that unit's control outputs plus decoded operands, and presents them to the EX stage.
- Contains load-use hazard detection: inserts a bubble and stalls fetch/decode on a hazard.
- Kills the decoded instruction on a taken-branch flush.

Parameters:
- XLEN, 64, datapath width (register operands, immediate, PC).
- CNT_W, 32, width of saturating bubble counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- idValid  input  1  ID holds a real instruction
- idALUOp  input  2  from decode control
- idBranch, idMemRead, idMemtoReg, idMemWrite, idALUSrc, idRegWrite  input  1 each  from decode control
- idReadData1, idReadData2  input  XLEN  register-file read data
- idImm  input  XLEN  sign-extended immediate
- idPc  input  XLEN  instruction PC
- idRs1, idRs2, idRd  input  5  register indices
- idFunct  input  4  {instr[30], instr[14:12]}
- flush  input  1  taken branch resolved downstream; kill ID instruction
- stall  output  1  combinational; hold PC and IF/ID this cycle
- exValid  output  1  registered valid
- exALUOp  output  2  registered control
- exBranch, exMemRead, exMemtoReg, exMemWrite, exALUSrc, exRegWrite  output  1 each  registered control
- exReadData1, exReadData2, exImm, exPc  output  XLEN  registered data
- exRs1, exRs2, exRd  output  5  registered indices
- exFunct  output  4  registered funct
- bubbleCount  output  CNT_W  saturating count of hazard bubbles inserted

Behaviour:
- Reset (rst_n low, async): every ex* output = 0, exValid = 0, bubbleCount = 0. stall is combinational and reads 0 because exValid = 0.
- Hazard detection:
  - hazard = exValid & exMemRead & (exRd != 0) & idValid & ((exRd == idRs1) | ((exRd == idRs2) & (~idALUSrc | idMemWrite))).
  - stall = hazard & ~flush.
- Per-edge update, priority order:
  1. flush = 1: load bubble (exValid and all seven control outputs = 0; data fields don't-care, implementation holds 0). bubbleCount unchanged.
  2. hazard = 1: load bubble. bubbleCount += 1, saturating at all-ones.
  3. Otherwise: capture all id* inputs into ex* outputs. exValid = idValid. If idValid = 0, control outputs are forced to 0.
- A bubble's control outputs must be all-zero. A zero exRegWrite and zero exMemWrite guarantees no architectural side effect.
- Latency: 1 cycle from ID inputs to EX outputs. No combinational path from id* to ex*.
- A stall lasts exactly one cycle per load-use pair. After the bubble, exMemRead = 0, so hazard clears and the held instruction enters the next cycle.
- rd = x0 never causes a hazard.
- flush and hazard in the same cycle: flush wins, stall = 0, no count increment.
- Reset asserted mid-operation clears state immediately, independent of clk. First capture occurs on the first rising edge after rst_n rises.
- bubbleCount wraps never; it holds at 2^CNT_W-1.

Test Plan:
- Reset: drive inputs nonzero, assert rst_n low between edges -> all ex* = 0 and bubbleCount = 0 immediately; stall = 0.
- Pass-through: add x5,x6,x7 (ALUOp=10, regWrite=1, readData1=0x10, readData2=0x20), idValid=1 -> next edge exALUOp=10, exRegWrite=1, exReadData1=0x10, exReadData2=0x20, exRd=5, stall never high.
- Load-use: ld x5 (memRead=1, rd=5) followed by add x8,x5,x9 -> stall=1 for exactly one cycle; next edge EX control all 0; the edge after, EX holds the add with exRs1=5; bubbleCount=1.
- No false hazard:
  - ld x0 followed by add using rs1=0 -> stall=0.
  - ld x5 followed by addi x8,x1,3 (ALUSrc=1, rs2 field=5) -> stall=0.
  - ld x5 followed by sd x5,0(x1) (rs2=5, memWrite=1) -> stall=1.
- Flush priority: load-use condition present with flush=1 -> stall=0, EX gets bubble, bubbleCount unchanged.
- Saturation: CNT_W=2, force 5 load-use pairs -> bubbleCount reaches 3 and stays 3.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the RV64 pipeline, with load-use hazard detection,
// bubble insertion on hazard or taken-branch flush, and a saturating bubble counter.
module id_ex_stage_reg #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idValid,
    input  logic [1:0]       idALUOp,
    input  logic             idBranch,
    input  logic             idMemRead,
    input  logic             idMemtoReg,
    input  logic             idMemWrite,
    input  logic             idALUSrc,
    input  logic             idRegWrite,
    input  logic [XLEN-1:0]  idReadData1,
    input  logic [XLEN-1:0]  idReadData2,
    input  logic [XLEN-1:0]  idImm,
    input  logic [XLEN-1:0]  idPc,
    input  logic [4:0]       idRs1,
    input  logic [4:0]       idRs2,
    input  logic [4:0]       idRd,
    input  logic [3:0]       idFunct,
    input  logic             flush,
    output logic             stall,
    output logic             exValid,
    output logic [1:0]       exALUOp,
    output logic             exBranch,
    output logic             exMemRead,
    output logic             exMemtoReg,
    output logic             exMemWrite,
    output logic             exALUSrc,
    output logic             exRegWrite,
    output logic [XLEN-1:0]  exReadData1,
    output logic [XLEN-1:0]  exReadData2,
    output logic [XLEN-1:0]  exImm,
    output logic [XLEN-1:0]  exPc,
    output logic [4:0]       exRs1,
    output logic [4:0]       exRs2,
    output logic [4:0]       exRd,
    output logic [3:0]       exFunct,
    output logic [CNT_W-1:0] bubbleCount
);

    typedef struct packed {
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       memto_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    ctrl_t            id_ctrl;
    logic             hazard;

    assign id_ctrl = '{alu_op:    idALUOp,
                       branch:    idBranch,
                       mem_read:  idMemRead,
                       memto_reg: idMemtoReg,
                       mem_write: idMemWrite,
                       alu_src:   idALUSrc,
                       reg_write: idRegWrite};

    // rs2 only matters when it is actually read as a register: R-type/branch (ALUSrc=0) or store data.
    assign hazard = stage_q.valid && stage_q.ctrl.mem_read && (stage_q.rd != 5'd0) && idValid &&
                    ((stage_q.rd == idRs1) ||
                     ((stage_q.rd == idRs2) && (!idALUSrc || idMemWrite)));

    assign stall = hazard & ~flush;

    always_comb begin
        // NOTE: defaults first so every path assigns every bit; otherwise latches are inferred.
        stage_d      = '0;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            stage_d = '0;
        end else if (hazard) begin
            stage_d = '0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end else begin
            stage_d.valid = idValid;
            stage_d.ctrl  = idValid ? id_ctrl : '0;
            stage_d.rd1   = idReadData1;
            stage_d.rd2   = idReadData2;
            stage_d.imm   = idImm;
            stage_d.pc    = idPc;
            stage_d.rs1   = idRs1;
            stage_d.rs2   = idRs2;
            stage_d.rd    = idRd;
            stage_d.funct = idFunct;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign exValid     = stage_q.valid;
    assign exALUOp     = stage_q.ctrl.alu_op;
    assign exBranch    = stage_q.ctrl.branch;
    assign exMemRead   = stage_q.ctrl.mem_read;
    assign exMemtoReg  = stage_q.ctrl.memto_reg;
    assign exMemWrite  = stage_q.ctrl.mem_write;
    assign exALUSrc    = stage_q.ctrl.alu_src;
    assign exRegWrite  = stage_q.ctrl.reg_write;
    assign exReadData1 = stage_q.rd1;
    assign exReadData2 = stage_q.rd2;
    assign exImm       = stage_q.imm;
    assign exPc        = stage_q.pc;
    assign exRs1       = stage_q.rs1;
    assign exRs2       = stage_q.rs2;
    assign exRd        = stage_q.rd;
    assign exFunct     = stage_q.funct;
    assign bubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed table, randomized run against a
// behavioural model, asynchronous reset, and bubble-counter saturation (CNT_W=2 instance).
module tb_id_ex_stage_reg;

    localparam int XLEN = 64;

    typedef struct {
        bit        valid;
        bit [1:0]  aluop;
        bit        branch, memread, memtoreg, memwrite, alusrc, regwrite;
        bit [63:0] r1, r2, imm, pc;
        bit [4:0]  rs1, rs2, rd;
        bit [3:0]  funct;
        bit        flush;
    } vec_t;

    typedef struct {
        vec_t      v;
        bit        exp_stall;
        bit        exp_valid;
        bit [4:0]  exp_rd;
        int        exp_cnt;
    } row_t;

    typedef struct {
        bit        valid;
        bit [1:0]  aluop;
        bit        branch, memread, memtoreg, memwrite, alusrc, regwrite;
        bit [63:0] r1, r2, imm, pc;
        bit [4:0]  rs1, rs2, rd;
        bit [3:0]  funct;
    } ex_t;

    logic clk, rst_n;
    logic idValid, idBranch, idMemRead, idMemtoReg, idMemWrite, idALUSrc, idRegWrite, flush;
    logic [1:0] idALUOp;
    logic [XLEN-1:0] idReadData1, idReadData2, idImm, idPc;
    logic [4:0] idRs1, idRs2, idRd;
    logic [3:0] idFunct;

    logic stall, exValid, exBranch, exMemRead, exMemtoReg, exMemWrite, exALUSrc, exRegWrite;
    logic [1:0] exALUOp;
    logic [XLEN-1:0] exReadData1, exReadData2, exImm, exPc;
    logic [4:0] exRs1, exRs2, exRd;
    logic [3:0] exFunct;
    logic [31:0] bubbleCount;

    logic s_stall, s_exValid, s_exBranch, s_exMemRead, s_exMemtoReg, s_exMemWrite, s_exALUSrc, s_exRegWrite;
    logic [1:0] s_exALUOp;
    logic [XLEN-1:0] s_exReadData1, s_exReadData2, s_exImm, s_exPc;
    logic [4:0] s_exRs1, s_exRs2, s_exRd;
    logic [3:0] s_exFunct;
    logic [1:0] s_bubbleCount;

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .idValid(idValid), .idALUOp(idALUOp),
        .idBranch(idBranch), .idMemRead(idMemRead), .idMemtoReg(idMemtoReg),
        .idMemWrite(idMemWrite), .idALUSrc(idALUSrc), .idRegWrite(idRegWrite),
        .idReadData1(idReadData1), .idReadData2(idReadData2), .idImm(idImm), .idPc(idPc),
        .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .idFunct(idFunct), .flush(flush),
        .stall(stall), .exValid(exValid), .exALUOp(exALUOp), .exBranch(exBranch),
        .exMemRead(exMemRead), .exMemtoReg(exMemtoReg), .exMemWrite(exMemWrite),
        .exALUSrc(exALUSrc), .exRegWrite(exRegWrite), .exReadData1(exReadData1),
        .exReadData2(exReadData2), .exImm(exImm), .exPc(exPc), .exRs1(exRs1),
        .exRs2(exRs2), .exRd(exRd), .exFunct(exFunct), .bubbleCount(bubbleCount)
    );

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .idValid(idValid), .idALUOp(idALUOp),
        .idBranch(idBranch), .idMemRead(idMemRead), .idMemtoReg(idMemtoReg),
        .idMemWrite(idMemWrite), .idALUSrc(idALUSrc), .idRegWrite(idRegWrite),
        .idReadData1(idReadData1), .idReadData2(idReadData2), .idImm(idImm), .idPc(idPc),
        .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .idFunct(idFunct), .flush(flush),
        .stall(s_stall), .exValid(s_exValid), .exALUOp(s_exALUOp), .exBranch(s_exBranch),
        .exMemRead(s_exMemRead), .exMemtoReg(s_exMemtoReg), .exMemWrite(s_exMemWrite),
        .exALUSrc(s_exALUSrc), .exRegWrite(s_exRegWrite), .exReadData1(s_exReadData1),
        .exReadData2(s_exReadData2), .exImm(s_exImm), .exPc(s_exPc), .exRs1(s_exRs1),
        .exRs2(s_exRs2), .exRd(s_exRd), .exFunct(s_exFunct), .bubbleCount(s_bubbleCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    ex_t m_ex;
    longint m_cnt;
    int m_cnt_sat;
    bit [63:0] pc_ctr = 64'h1000;

    task automatic check(string name, logic [299:0] act, logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit valid, bit [1:0] aluop, bit [5:0] ctl, bit [4:0] rs1,
                                bit [4:0] rs2, bit [4:0] rd, bit [63:0] r1, bit [63:0] r2,
                                bit [63:0] imm, bit fl);
        vec_t v;
        v.valid = valid; v.aluop = aluop;
        {v.branch, v.memread, v.memtoreg, v.memwrite, v.alusrc, v.regwrite} = ctl;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.r1 = r1; v.r2 = r2; v.imm = imm;
        v.pc = 64'h0; v.funct = {1'b0, rd[2:0]}; v.flush = fl;
        return v;
    endfunction

    task automatic drive(vec_t v);
        idValid = v.valid; idALUOp = v.aluop; idBranch = v.branch; idMemRead = v.memread;
        idMemtoReg = v.memtoreg; idMemWrite = v.memwrite; idALUSrc = v.alusrc;
        idRegWrite = v.regwrite; idReadData1 = v.r1; idReadData2 = v.r2; idImm = v.imm;
        idPc = v.pc; idRs1 = v.rs1; idRs2 = v.rs2; idRd = v.rd; idFunct = v.funct;
        flush = v.flush;
    endtask

    // Load-use rule as stated: a valid load in EX writing a nonzero rd that the ID instruction reads.
    function automatic bit model_hazard(vec_t v);
        bit reads_rs2 = !v.alusrc || v.memwrite;
        return m_ex.valid && m_ex.memread && (m_ex.rd != 0) && v.valid &&
               ((m_ex.rd == v.rs1) || ((m_ex.rd == v.rs2) && reads_rs2));
    endfunction

    function automatic ex_t empty_ex();
        ex_t e;
        e = '{default: '0};
        return e;
    endfunction

    task automatic model_edge(vec_t v);
        bit haz = model_hazard(v);
        if (v.flush) begin
            m_ex = empty_ex();
        end else if (haz) begin
            m_ex = empty_ex();
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt_sat < 3) m_cnt_sat++;
        end else begin
            m_ex.valid = v.valid;
            m_ex.aluop = v.valid ? v.aluop : 2'b00;
            {m_ex.branch, m_ex.memread, m_ex.memtoreg, m_ex.memwrite, m_ex.alusrc, m_ex.regwrite} =
                v.valid ? {v.branch, v.memread, v.memtoreg, v.memwrite, v.alusrc, v.regwrite} : 6'b0;
            m_ex.r1 = v.r1; m_ex.r2 = v.r2; m_ex.imm = v.imm; m_ex.pc = v.pc;
            m_ex.rs1 = v.rs1; m_ex.rs2 = v.rs2; m_ex.rd = v.rd; m_ex.funct = v.funct;
        end
    endtask

    task automatic check_outputs(string tag);
        logic [299:0] act, exp, act_s;
        act = {exValid, exALUOp, exBranch, exMemRead, exMemtoReg, exMemWrite, exALUSrc,
               exRegWrite, exReadData1, exReadData2, exImm, exPc, exRs1, exRs2, exRd, exFunct};
        act_s = {s_exValid, s_exALUOp, s_exBranch, s_exMemRead, s_exMemtoReg, s_exMemWrite,
                 s_exALUSrc, s_exRegWrite, s_exReadData1, s_exReadData2, s_exImm, s_exPc,
                 s_exRs1, s_exRs2, s_exRd, s_exFunct};
        exp = {m_ex.valid, m_ex.aluop, m_ex.branch, m_ex.memread, m_ex.memtoreg, m_ex.memwrite,
               m_ex.alusrc, m_ex.regwrite, m_ex.r1, m_ex.r2, m_ex.imm, m_ex.pc,
               m_ex.rs1, m_ex.rs2, m_ex.rd, m_ex.funct};
        check({tag, ".ex"}, act, exp);
        check({tag, ".ex_sat"}, act_s, exp);
        check({tag, ".count"}, 300'(bubbleCount), 300'(m_cnt));
        check({tag, ".count_sat"}, 300'(s_bubbleCount), 300'(m_cnt_sat));
    endtask

    task automatic apply(vec_t v, string tag);
        bit exp_stall;
        @(negedge clk);
        v.pc = pc_ctr;
        pc_ctr += 64'd4;
        drive(v);
        #1;
        exp_stall = model_hazard(v) && !v.flush;
        check({tag, ".stall"}, 300'(stall), 300'(exp_stall));
        check({tag, ".stall_sat"}, 300'(s_stall), 300'(exp_stall));
        @(posedge clk);
        model_edge(v);
        #1;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        m_ex = empty_ex();
        m_cnt = 0;
        m_cnt_sat = 0;
    endtask

    row_t tbl[16];

    initial begin
        // ctl bits: {branch, memread, memtoreg, memwrite, alusrc, regwrite}
        tbl[0]  = '{mk(1, 2'b10, 6'b000001, 6, 7, 5, 64'h10, 64'h20, 0, 0), 0, 1, 5, 0}; // add x5,x6,x7
        tbl[1]  = '{mk(1, 2'b00, 6'b011011, 1, 0, 5, 64'h1, 0, 8, 0),       0, 1, 5, 0}; // ld x5
        tbl[2]  = '{mk(1, 2'b10, 6'b000001, 5, 9, 8, 64'h3, 64'h4, 0, 0),   1, 0, 0, 1}; // add x8,x5,x9
        tbl[3]  = '{mk(1, 2'b10, 6'b000001, 5, 9, 8, 64'h3, 64'h4, 0, 0),   0, 1, 8, 1}; // held add
        tbl[4]  = '{mk(1, 2'b00, 6'b011011, 1, 0, 0, 64'h1, 0, 8, 0),       0, 1, 0, 1}; // ld x0
        tbl[5]  = '{mk(1, 2'b10, 6'b000001, 0, 9, 8, 64'h0, 64'h4, 0, 0),   0, 1, 8, 1}; // add rs1=x0
        tbl[6]  = '{mk(1, 2'b00, 6'b011011, 1, 0, 5, 64'h1, 0, 8, 0),       0, 1, 5, 1}; // ld x5
        tbl[7]  = '{mk(1, 2'b00, 6'b000011, 1, 5, 8, 64'h7, 64'h9, 3, 0),   0, 1, 8, 1}; // addi, rs2 field=5
        tbl[8]  = '{mk(1, 2'b00, 6'b011011, 1, 0, 5, 64'h1, 0, 8, 0),       0, 1, 5, 1}; // ld x5
        tbl[9]  = '{mk(1, 2'b00, 6'b000110, 1, 5, 0, 64'h1, 64'h55, 0, 0),  1, 0, 0, 2}; // sd x5,0(x1)
        tbl[10] = '{mk(1, 2'b00, 6'b000110, 1, 5, 0, 64'h1, 64'h55, 0, 0),  0, 1, 0, 2}; // held sd
        tbl[11] = '{mk(1, 2'b00, 6'b011011, 1, 0, 5, 64'h1, 0, 8, 0),       0, 1, 5, 2}; // ld x5
        tbl[12] = '{mk(1, 2'b10, 6'b000001, 5, 9, 8, 64'h3, 64'h4, 0, 1),   0, 0, 0, 2}; // use + flush
        tbl[13] = '{mk(0, 2'b10, 6'b000001, 5, 9, 5, 64'h3, 64'h4, 0, 0),   0, 0, 5, 2}; // invalid ID
        tbl[14] = '{mk(1, 2'b00, 6'b011011, 1, 0, 5, 64'h1, 0, 8, 0),       0, 1, 5, 2}; // ld x5
        tbl[15] = '{mk(0, 2'b10, 6'b000001, 5, 9, 8, 64'h3, 64'h4, 0, 0),   0, 0, 8, 2}; // invalid use

        // Reset held with nonzero inputs, including across a clock edge.
        rst_n = 1'b0;
        drive(mk(1, 2'b11, 6'b111111, 3, 4, 5, 64'hAA, 64'hBB, 64'hCC, 0));
        model_reset();
        #2;
        check("reset.stall", 300'(stall), 300'(0));
        check_outputs("reset");
        #5;
        check_outputs("reset_edge");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            string tag = $sformatf("vec%0d", i);
            apply(tbl[i].v, tag);
            check({tag, ".tbl_stall"}, 300'(stall), 300'(0));
            check({tag, ".tbl_valid"}, 300'(exValid), 300'(tbl[i].exp_valid));
            check({tag, ".tbl_rd"}, 300'(exRd), 300'(tbl[i].exp_rd));
            check({tag, ".tbl_cnt"}, 300'(bubbleCount), 300'(tbl[i].exp_cnt));
        end
        // The stall of a load-use pair must be visible before its edge; re-check the table's stall flags.
        begin
            vec_t ld5, use5;
            ld5  = tbl[1].v;
            use5 = tbl[2].v;
            apply(ld5, "pre_ld");
            @(negedge clk);
            drive(use5);
            #1;
            check("tbl_stall_live", 300'(stall), 300'(tbl[2].exp_stall));
            model_edge(use5);
            @(posedge clk);
            #1;
            check_outputs("tbl_stall_live");
        end

        // Randomized traffic over a small register set so load-use pairs are frequent.
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = mk($urandom_range(0, 3) != 0, 2'($urandom), 6'($urandom),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) v.memread = 1'b1;
            v.funct = 4'($urandom);
            apply(v, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset mid-cycle, well away from either clock edge.
        @(negedge clk);
        drive(tbl[1].v);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midreset.stall", 300'(stall), 300'(0));
        check_outputs("midreset");
        #4;
        rst_n = 1'b1;

        // Five load-use pairs: CNT_W=2 instance saturates at 3, 32-bit instance counts to 5.
        for (int k = 0; k < 5; k++) begin
            apply(tbl[1].v, $sformatf("sat_ld%0d", k));
            apply(tbl[2].v, $sformatf("sat_use%0d", k));
            apply(tbl[3].v, $sformatf("sat_held%0d", k));
        end
        check("sat.count_sat_final", 300'(s_bubbleCount), 300'(3));
        check("sat.count_final", 300'(bubbleCount), 300'(5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
